// File: rtl/cell_empty_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cell_empty_fill_ctrl
// Brief    : Packs one cell's incoming particle positions into its empty-cell
//            RAM from address 1 upward, then writes the particle count to
//            address 0.
// Revision : 1.0 - initial release
// ============================================================================
module cell_empty_fill_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_end,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    output logic                  mem_rden,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  overflow,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] c_cap = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] c_one = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_WCNT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_data;
    logic                    r_mem_wren;
    logic [ADDR_WIDTH-1:0]   r_particle_count;
    logic                    r_overflow;
    logic                    r_done;
    logic                    w_start;
    logic                    w_accept;
    logic                    w_full;

    // The done cycle is already IDLE; a start seen alongside done is ignored.
    assign w_start  = start && (r_state == S_IDLE) && !r_done;
    assign w_accept = in_valid && (r_state == S_FILL);
    assign w_full   = (r_cnt == c_cap);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_FILL;
            S_FILL:  if (in_end) w_next = S_WCNT;
            S_WCNT:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr         <= c_one;
            r_cnt            <= '0;
            r_mem_addr       <= '0;
            r_mem_data       <= '0;
            r_mem_wren       <= 1'b0;
            r_particle_count <= '0;
            r_overflow       <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_mem_wren <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_wr_ptr   <= c_one;
                        r_cnt      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                S_FILL: begin
                    // A full cell keeps accepting so upstream never stalls; extra beats are dropped.
                    if (w_accept) begin
                        if (!w_full) begin
                            r_mem_addr <= r_wr_ptr;
                            r_mem_data <= in_data;
                            r_mem_wren <= 1'b1;
                            r_wr_ptr   <= r_wr_ptr + c_one;
                            r_cnt      <= r_cnt + c_one;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                S_WCNT: begin
                    r_mem_addr <= '0;
                    r_mem_data <= DATA_WIDTH'(r_cnt);
                    r_mem_wren <= 1'b1;
                end
                S_DONE: begin
                    r_particle_count <= r_cnt;
                    r_done           <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready       = (r_state == S_FILL);
    assign mem_addr       = r_mem_addr;
    assign mem_data       = r_mem_data;
    assign mem_wren       = r_mem_wren;
    assign mem_rden       = 1'b0;
    assign particle_count = r_particle_count;
    assign overflow       = r_overflow;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cell_empty_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_empty_fill_ctrl
// Brief    : Randomized bench for cell_empty_fill_ctrl; a default-depth and a
//            4-deep instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_empty_fill_ctrl;

    localparam int DW   = 96;
    localparam int AW   = 8;
    localparam int PN_L = 220;
    localparam int PN_S = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_end;
    logic [DW-1:0] in_data;

    logic          in_ready_l, mem_wren_l, mem_rden_l, overflow_l, done_l;
    logic [AW-1:0] mem_addr_l, particle_count_l;
    logic [DW-1:0] mem_data_l;
    logic          in_ready_s, mem_wren_s, mem_rden_s, overflow_s, done_s;
    logic [AW-1:0] mem_addr_s, particle_count_s;
    logic [DW-1:0] mem_data_s;

    cell_empty_fill_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN_L), .ADDR_WIDTH(AW)) dut_l (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .in_end(in_end), .mem_addr(mem_addr_l), .mem_data(mem_data_l),
        .mem_wren(mem_wren_l), .mem_rden(mem_rden_l), .particle_count(particle_count_l),
        .overflow(overflow_l), .done(done_l)
    );

    cell_empty_fill_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN_S), .ADDR_WIDTH(AW)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_end(in_end), .mem_addr(mem_addr_s), .mem_data(mem_data_s),
        .mem_wren(mem_wren_s), .mem_rden(mem_rden_s), .particle_count(particle_count_s),
        .overflow(overflow_s), .done(done_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t q_l[$];
    wr_t q_s[$];
    wr_t w_l, w_s;
    int  done_seen = 0;

    // Every RAM write observed on either port, tagged with its cycle.
    always @(negedge clk) begin
        if (mem_wren_l === 1'b1) begin
            w_l.c = cyc; w_l.a = mem_addr_l; w_l.d = mem_data_l;
            q_l.push_back(w_l);
        end
        if (mem_wren_s === 1'b1) begin
            w_s.c = cyc; w_s.a = mem_addr_s; w_s.d = mem_data_s;
            q_s.push_back(w_s);
        end
        if (done_l === 1'b1 || done_s === 1'b1) done_seen = done_seen + 1;
    end

    int tests = 0;
    int fails = 0;

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // One fill phase: start, n beats with random gaps, in_end; writes and results
    // compared against the packing rule for each instance's capacity.
    task automatic do_phase(input string name, input int n, input int gmin, input int gmax,
                            input bit coincident, input bit noisy, input bit start_on_done);
        logic [DW-1:0] beats[$];
        int            acc[$];
        int            e, g, base_l, base_s, cap, nst;
        wr_t           q[$];
        e      = 0;
        base_l = q_l.size();
        base_s = q_s.size();
        for (int i = 0; i < n; i++) beats.push_back(rand_word());
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(gmax, gmin);
            for (int k = 0; k < g; k++) begin
                start = noisy;
                @(posedge clk); #1;
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = beats[i];
            in_end   = coincident && (i == n - 1);
            if (in_end) e = cyc;
            acc.push_back(cyc);
            tests++;
            if (in_ready_l !== 1'b1 || in_ready_s !== 1'b1) begin
                fails++;
                $display("FAIL %s in_ready beat %0d: got %b/%b want 1", name, i, in_ready_l, in_ready_s);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_end   = 1'b0;
            in_data  = rand_word();
        end
        if (!(coincident && n > 0)) begin
            in_end = 1'b1;
            e      = cyc;
            @(posedge clk); #1;
            in_end = 1'b0;
        end
        for (int k = 1; k <= 3; k++) begin
            start    = noisy || (k == 3 && start_on_done);
            in_valid = noisy;
            in_end   = noisy;
            in_data  = rand_word();
            @(negedge clk);
            tests++;
            if (done_l !== (k == 3) || done_s !== (k == 3)) begin
                fails++;
                $display("FAIL %s done at E+%0d: got %b/%b want %0d", name, k, done_l, done_s, (k == 3));
            end
            if (k == 3) begin
                tests++;
                if (particle_count_l !== AW'(n < PN_L - 1 ? n : PN_L - 1) ||
                    overflow_l !== (n > PN_L - 1) || mem_rden_l !== 1'b0) begin
                    fails++;
                    $display("FAIL %s result_l: got cnt=%0d ov=%b rden=%b want cnt=%0d ov=%0d",
                             name, particle_count_l, overflow_l, mem_rden_l,
                             (n < PN_L - 1 ? n : PN_L - 1), (n > PN_L - 1));
                end
                tests++;
                if (particle_count_s !== AW'(n < PN_S - 1 ? n : PN_S - 1) ||
                    overflow_s !== (n > PN_S - 1) || mem_rden_s !== 1'b0) begin
                    fails++;
                    $display("FAIL %s result_s: got cnt=%0d ov=%b rden=%b want cnt=%0d ov=%0d",
                             name, particle_count_s, overflow_s, mem_rden_s,
                             (n < PN_S - 1 ? n : PN_S - 1), (n > PN_S - 1));
                end
            end
            @(posedge clk); #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_end   = 1'b0;
        tests++;
        if (in_ready_l !== 1'b0 || in_ready_s !== 1'b0) begin
            fails++;
            $display("FAIL %s start_with_done not ignored: in_ready %b/%b want 0", name, in_ready_l, in_ready_s);
        end
        for (int u = 0; u < 2; u++) begin
            q.delete();
            if (u == 0) begin
                cap = PN_L - 1;
                for (int j = base_l; j < q_l.size(); j++) q.push_back(q_l[j]);
            end else begin
                cap = PN_S - 1;
                for (int j = base_s; j < q_s.size(); j++) q.push_back(q_s[j]);
            end
            nst = (n < cap) ? n : cap;
            tests++;
            if (q.size() != nst + 1) begin
                fails++;
                $display("FAIL %s write_count[%0d]: got %0d want %0d", name, u, q.size(), nst + 1);
            end else begin
                for (int i = 0; i < nst; i++) begin
                    tests++;
                    if (q[i].a !== AW'(i + 1) || q[i].d !== beats[i] || q[i].c != acc[i] + 1) begin
                        fails++;
                        $display("FAIL %s data_write[%0d][%0d]: got a=%0d c=%0d d=%h want a=%0d c=%0d d=%h",
                                 name, u, i, q[i].a, q[i].c, q[i].d, i + 1, acc[i] + 1, beats[i]);
                    end
                end
                tests++;
                if (q[nst].a !== '0 || q[nst].d !== DW'(nst) || q[nst].c != e + 2) begin
                    fails++;
                    $display("FAIL %s count_write[%0d]: got a=%0d c=%0d d=%0d want a=0 c=%0d d=%0d",
                             name, u, q[nst].a, q[nst].c, q[nst].d, e + 2, nst);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (in_ready_l !== 1'b0 || mem_wren_l !== 1'b0 || mem_addr_l !== '0 || mem_data_l !== '0 ||
            mem_rden_l !== 1'b0 || particle_count_l !== '0 || overflow_l !== 1'b0 || done_l !== 1'b0) begin
            fails++;
            $display("FAIL reset_l: got rdy=%b wr=%b a=%0d d=%h cnt=%0d ov=%b dn=%b want all 0",
                     in_ready_l, mem_wren_l, mem_addr_l, mem_data_l, particle_count_l, overflow_l, done_l);
        end
        tests++;
        if (in_ready_s !== 1'b0 || mem_wren_s !== 1'b0 || mem_addr_s !== '0 || mem_data_s !== '0 ||
            mem_rden_s !== 1'b0 || particle_count_s !== '0 || overflow_s !== 1'b0 || done_s !== 1'b0) begin
            fails++;
            $display("FAIL reset_s: got rdy=%b wr=%b a=%0d d=%h cnt=%0d ov=%b dn=%b want all 0",
                     in_ready_s, mem_wren_s, mem_addr_s, mem_data_s, particle_count_s, overflow_s, done_s);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_phase("basic", 3, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        do_phase("empty", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        do_phase("overflow5", 5, 0, 0, 1'b0, 1'b0, 1'b0);
        do_phase("overflow_large", PN_L + 2, 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        do_phase("gaps", 4, 2, 2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_phase("b2b_a", 2, 0, 0, 1'b0, 1'b0, 1'b1);
        do_phase("b2b_b", 3, 0, 1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_start_ignored();
        do_phase("start_ignored", 4, 1, 2, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int base_l, base_s, base_d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = rand_word();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        base_l = q_l.size();
        base_s = q_s.size();
        base_d = done_seen;
        @(negedge clk);
        tests++;
        if (mem_wren_l !== 1'b0 || in_ready_l !== 1'b0 || done_l !== 1'b0 || mem_addr_l !== '0 ||
            particle_count_l !== '0 || overflow_l !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_l: got wr=%b rdy=%b dn=%b a=%0d cnt=%0d ov=%b want all 0",
                     mem_wren_l, in_ready_l, done_l, mem_addr_l, particle_count_l, overflow_l);
        end
        tests++;
        if (mem_wren_s !== 1'b0 || in_ready_s !== 1'b0 || done_s !== 1'b0 || mem_addr_s !== '0 ||
            particle_count_s !== '0 || overflow_s !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_s: got wr=%b rdy=%b dn=%b a=%0d cnt=%0d ov=%b want all 0",
                     mem_wren_s, in_ready_s, done_s, mem_addr_s, particle_count_s, overflow_s);
        end
        // Traffic while idle must be ignored.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_end   = k[0];
            in_data  = rand_word();
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_end   = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (q_l.size() != base_l || q_s.size() != base_s || done_seen != base_d) begin
            fails++;
            $display("FAIL reset_mid_quiet: got writes=%0d/%0d dones=%0d want 0/0/0",
                     q_l.size() - base_l, q_s.size() - base_s, done_seen - base_d);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++)
            do_phase("random", $urandom_range(9, 0), 0, $urandom_range(3, 0),
                     1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_end   = 1'b0;
        in_data  = '0;
        test_reset();
        test_basic();
        test_empty();
        test_overflow();
        test_gaps();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_basic();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
